// File: rtl/vending_if.sv
// vending_if: customer-to-controller signals; master is the customer side, slave the controller.
interface vending_if #(
  parameter int CREDIT_W = 5
);
  logic [3:0]          price;
  logic                req;
  logic                coin_valid;
  logic [2:0]          coin_val;
  logic                cancel;
  logic                busy;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic                change_valid;
  logic [CREDIT_W-1:0] change;
  logic                sold_out;
  modport master (
    output price, req, coin_valid, coin_val, cancel,
    input  busy, credit, dispense, change_valid, change, sold_out
  );
  modport slave (
    input  price, req, coin_valid, coin_val, cancel,
    output busy, credit, dispense, change_valid, change, sold_out
  );
endinterface

// File: rtl/vending_controller.sv
// vending_controller: credit-collecting vend FSM with change, refund and stock count.
// Optional COLLECT inactivity auto-refund when VENDING_TIMEOUT_EN is defined.
module vending_controller #(
  parameter int CREDIT_W       = 5,
  parameter int STOCK_INIT     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic      clk,
  input logic      rst,
  vending_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;
  state_t              r_state, w_next;
  logic [CREDIT_W-1:0] r_credit, w_credit, w_sum;
  logic [CREDIT_W:0]   w_add;
  logic [3:0]          r_price, r_stock;
  logic                w_coin, w_timeout;
  assign w_coin = bus.coin_valid && bus.coin_val != 3'd0;
  assign w_add  = {1'b0, r_credit} + (CREDIT_W+1)'(bus.coin_val);
  assign w_sum  = w_add[CREDIT_W] ? '1 : w_add[CREDIT_W-1:0];
`ifdef VENDING_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_idle;
  // counter holds the idle cycles already spent; this cycle is the last allowed one
  assign w_timeout = r_idle == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || r_state != COLLECT || w_coin) r_idle <= '0;
    else r_idle <= r_idle + 1'b1;
  end
`else
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
  always_comb begin
    w_next   = r_state;
    w_credit = r_credit;
    case (r_state)
      IDLE: begin
        w_next = (bus.req && bus.price != 4'd0 && r_stock != 4'd0) ? COLLECT : IDLE;
        w_credit = '0;
      end
      COLLECT: begin
        w_credit = w_coin ? w_sum : r_credit;
        w_next = (w_credit >= CREDIT_W'(r_price)) ? VEND :
                 (bus.cancel || (w_timeout && !w_coin)) ? REFUND : COLLECT;
      end
      default: begin
        w_next   = IDLE;
        w_credit = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_credit <= '0;
      r_price  <= '0;
      r_stock  <= 4'(STOCK_INIT);
    end else begin
      r_state  <= w_next;
      r_credit <= w_credit;
      if (r_state == IDLE && w_next == COLLECT) r_price <= bus.price;
      if (r_state == VEND) r_stock <= r_stock - 4'd1;
    end
  end
  assign bus.busy         = r_state != IDLE;
  assign bus.credit       = r_credit;
  assign bus.dispense     = r_state == VEND;
  assign bus.change_valid = r_state == VEND || r_state == REFUND;
  assign bus.change       = r_state == VEND   ? r_credit - CREDIT_W'(r_price) :
                            r_state == REFUND ? r_credit : '0;
  assign bus.sold_out     = r_stock == 4'd0;
endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: directed plan plus random traffic against a transaction-level model.
module tb_vending_controller;
  localparam int CW = 5;
  localparam int SI = 8;
`ifdef VENDING_TIMEOUT_EN
  localparam int TO = 10;
`else
  localparam int TO = 255;
`endif
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  vending_if #(.CREDIT_W(CW)) bus ();
  vending_controller #(.CREDIT_W(CW), .STOCK_INIT(SI), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  bit m_active, m_pay, m_disp;
  int m_credit, m_price, m_stock, m_chg, m_idle;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask
  task automatic model_step();
    bit coin;
    coin = bus.coin_valid && bus.coin_val != 0;
    if (rst) begin
      m_active = 0; m_pay = 0; m_disp = 0; m_credit = 0; m_price = 0; m_stock = SI; m_chg = 0;
    end else if (m_pay) begin
      m_pay = 0;
      m_credit = 0;
      if (m_disp) m_stock--;
      m_disp = 0;
    end else if (!m_active) begin
      if (bus.req && bus.price != 0 && m_stock != 0) begin
        m_active = 1; m_price = bus.price; m_credit = 0; m_idle = 0;
      end
    end else begin
      if (coin) begin
        m_credit = (m_credit + bus.coin_val > CMAX) ? CMAX : m_credit + bus.coin_val;
        m_idle = 0;
      end else m_idle++;
      if (m_credit >= m_price) begin
        m_active = 0; m_pay = 1; m_disp = 1; m_chg = m_credit - m_price;
      end else if (bus.cancel) begin
        m_active = 0; m_pay = 1; m_disp = 0; m_chg = m_credit;
`ifdef VENDING_TIMEOUT_EN
      end else if (m_idle == TO) begin
        m_active = 0; m_pay = 1; m_disp = 0; m_chg = m_credit;
`endif
      end
    end
  endtask
  task automatic compare_all();
    check("busy", int'(bus.busy), int'(m_active || m_pay));
    check("credit", int'(bus.credit), m_credit);
    check("dispense", int'(bus.dispense), int'(m_pay && m_disp));
    check("change_valid", int'(bus.change_valid), int'(m_pay));
    check("change", int'(bus.change), m_pay ? m_chg : 0);
    check("sold_out", int'(bus.sold_out), int'(m_stock == 0));
  endtask
  task automatic step(input logic r, input logic q, input logic [3:0] p,
                      input logic cv, input logic [2:0] v, input logic c);
    rst = r; bus.req = q; bus.price = p; bus.coin_valid = cv; bus.coin_val = v; bus.cancel = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask
  task automatic idle_step();
    step(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
  endtask
  task automatic coin(input logic [2:0] v, input logic c);
    step(1'b0, 1'b0, 4'd0, 1'b1, v, c);
  endtask
  task automatic request(input logic [3:0] p);
    step(1'b0, 1'b1, p, 1'b0, 3'd0, 1'b0);
  endtask
  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_sold_out", int'(bus.sold_out), 0);
    request(4'd7);
    check("req_busy", int'(bus.busy), 1);
    coin(3'd5, 1'b0);
    check("credit5", int'(bus.credit), 5);
    coin(3'd5, 1'b0);
    check("vend_disp", int'(bus.dispense), 1);
    check("vend_chg", int'(bus.change), 3);
    idle_step();
    check("post_vend_idle", int'(bus.busy), 0);
    request(4'd4);
    coin(3'd4, 1'b0);
    check("exact_cv", int'(bus.change_valid), 1);
    check("exact_chg", int'(bus.change), 0);
    idle_step();
    request(4'd9);
    coin(3'd3, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 3'd0, 1'b1);
    check("cancel_chg", int'(bus.change), 3);
    check("cancel_disp", int'(bus.dispense), 0);
    idle_step();
    request(4'd9);
    coin(3'd3, 1'b0);
    coin(3'd2, 1'b1);
    check("cancel_coin_chg", int'(bus.change), 5);
    idle_step();
    request(4'd15);
    coin(3'd7, 1'b0);
    coin(3'd7, 1'b0);
    coin(3'd7, 1'b0);
    check("p15_disp", int'(bus.dispense), 1);
    check("p15_chg", int'(bus.change), 6);
    idle_step();
    request(4'd0);
    check("price0_ignored", int'(bus.busy), 0);
`ifdef VENDING_TIMEOUT_EN
    request(4'd6);
    coin(3'd2, 1'b0);
    for (int i = 0; i < TO - 1; i++) idle_step();
    check("to_wait", int'(bus.change_valid), 0);
    idle_step();
    check("to_refund", int'(bus.change), 2);
    idle_step();
    request(4'd6);
    coin(3'd2, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0);
    check("rst_mid_credit", int'(bus.credit), 0);
    check("rst_mid_cv", int'(bus.change_valid), 0);
`endif
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom_range(0, 19) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
